// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store bus master: access sizes, FSM
// states, RISC-V fault cause codes and small decode helpers.
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_LD_ACCESS   = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ST_ACCESS   = 4'd7;

    // Encoding 3 behaves exactly like a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        logic [1:0] res;
        if (size == 2'd3) begin
            res = SIZE_W;
        end else begin
            res = size;
        end
        return res;
    endfunction

    // Halves need an even address, words a multiple of four.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic res;
        case (size)
            SIZE_B:  res = 1'b0;
            SIZE_H:  res = addr_lo[0];
            default: res = (addr_lo != 2'b00);
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: little-endian extraction/extension of load data
// and merge of sub-word store data into a previously read word.
// The merge path exists only when LSU_RMW_EN is defined; otherwise the store
// word is simply the right-aligned store data (only word stores reach the bus).
import lsu_pkg::*;

module lsu_lane_align (
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_data_o,
    input  logic [31:0] st_word_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] st_word_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte and half lanes of the load word.
    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_s = ld_word_i[7:0];
            2'd1:    byte_s = ld_word_i[15:8];
            2'd2:    byte_s = ld_word_i[23:16];
            default: byte_s = ld_word_i[31:24];
        endcase
        if (addr_lo_i[1]) begin
            half_s = ld_word_i[31:16];
        end else begin
            half_s = ld_word_i[15:0];
        end
    end

    // Zero- or sign-extend the selected lane to a full register value.
    always_comb begin
        case (size_i)
            SIZE_B: begin
                if (unsigned_i) begin
                    ld_data_o = {24'd0, byte_s};
                end else begin
                    ld_data_o = {{24{byte_s[7]}}, byte_s};
                end
            end
            SIZE_H: begin
                if (unsigned_i) begin
                    ld_data_o = {16'd0, half_s};
                end else begin
                    ld_data_o = {{16{half_s[15]}}, half_s};
                end
            end
            default: ld_data_o = ld_word_i;
        endcase
    end

`ifdef LSU_RMW_EN
    // Overwrite only the addressed lanes of the captured read word.
    always_comb begin
        st_word_o = st_word_i;
        case (size_i)
            SIZE_B: begin
                case (addr_lo_i)
                    2'd0:    st_word_o[7:0]   = st_data_i[7:0];
                    2'd1:    st_word_o[15:8]  = st_data_i[7:0];
                    2'd2:    st_word_o[23:16] = st_data_i[7:0];
                    default: st_word_o[31:24] = st_data_i[7:0];
                endcase
            end
            SIZE_H: begin
                if (addr_lo_i[1]) begin
                    st_word_o[31:16] = st_data_i[15:0];
                end else begin
                    st_word_o[15:0] = st_data_i[15:0];
                end
            end
            default: st_word_o = st_data_i;
        endcase
    end
`else
    logic unused_st_word_s;
    assign unused_st_word_s = ^st_word_i;
    assign st_word_o        = st_data_i;
`endif

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store bus master: converts byte/half/word CPU requests into
// word-aligned accesses on the MMIO data bus, with read-modify-write for
// sub-word stores and misaligned/unmapped fault reporting.
// Optional feature macro: LSU_RMW_EN (enables sub-word stores via RD->WR).
import lsu_pkg::*;

module lsu_bus_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_fault,
    output logic [3:0]        resp_cause,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_address,
    output logic [DATA_W-1:0] bus_write_data,
    input  logic [DATA_W-1:0] bus_read_data,
    input  logic              bus_selected
);

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rword_q, rword_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_fault_q, resp_fault_d;
    logic [3:0]        resp_cause_q, resp_cause_d;
    logic [DATA_W-1:0] ld_data_s;
    logic [DATA_W-1:0] st_word_s;

    // Load data comes straight off the bus during RD; store merge uses the
    // word captured in RD.
    lsu_lane_align u_lane (
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .addr_lo_i  (addr_q[1:0]),
        .ld_word_i  (bus_read_data),
        .ld_data_o  (ld_data_s),
        .st_word_i  (rword_q),
        .st_data_i  (wdata_q),
        .st_word_o  (st_word_s)
    );

    // Next-state decode, request capture and response field update.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rword_d      = rword_q;
        resp_rdata_d = resp_rdata_q;
        resp_fault_d = resp_fault_q;
        resp_cause_d = resp_cause_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = norm_size(req_size);
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (is_misaligned(norm_size(req_size), req_addr[1:0])) begin
                        state_d      = ST_RESP;
                        resp_fault_d = 1'b1;
                        resp_cause_d = req_we ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
                        resp_rdata_d = {DATA_W{1'b0}};
                    end else if (req_we && (norm_size(req_size) != SIZE_W)) begin
`ifdef LSU_RMW_EN
                        state_d = ST_RD;
`else
                        state_d      = ST_RESP;
                        resp_fault_d = 1'b1;
                        resp_cause_d = CAUSE_ST_ACCESS;
                        resp_rdata_d = {DATA_W{1'b0}};
`endif
                    end else if (req_we) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                rword_d = bus_read_data;
                if (!bus_selected) begin
                    state_d      = ST_RESP;
                    resp_fault_d = 1'b1;
                    resp_cause_d = we_q ? CAUSE_ST_ACCESS : CAUSE_LD_ACCESS;
                    resp_rdata_d = {DATA_W{1'b0}};
`ifdef LSU_RMW_EN
                end else if (we_q) begin
                    state_d = ST_WR;
`endif
                end else begin
                    state_d      = ST_RESP;
                    resp_fault_d = 1'b0;
                    resp_cause_d = 4'd0;
                    resp_rdata_d = ld_data_s;
                end
            end
            ST_WR: begin
                state_d      = ST_RESP;
                resp_rdata_d = {DATA_W{1'b0}};
                if (!bus_selected) begin
                    resp_fault_d = 1'b1;
                    resp_cause_d = CAUSE_ST_ACCESS;
                end else begin
                    resp_fault_d = 1'b0;
                    resp_cause_d = 4'd0;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and captured-request registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            size_q       <= SIZE_B;
            uns_q        <= 1'b0;
            addr_q       <= {ADDR_W{1'b0}};
            wdata_q      <= {DATA_W{1'b0}};
            rword_q      <= {DATA_W{1'b0}};
            resp_rdata_q <= {DATA_W{1'b0}};
            resp_fault_q <= 1'b0;
            resp_cause_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rword_q      <= rword_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
            resp_cause_q <= resp_cause_d;
        end
    end

    // Bus and handshake outputs decoded from the state register only, so a
    // bus write can never appear outside WR.
    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        resp_valid = (state_q == ST_RESP);
        resp_rdata = resp_rdata_q;
        resp_fault = resp_fault_q;
        resp_cause = resp_cause_q;
        bus_rw     = (state_q == ST_WR);
        if ((state_q == ST_RD) || (state_q == ST_WR)) begin
            bus_address = {addr_q[ADDR_W-1:2], 2'b00};
        end else begin
            bus_address = {ADDR_W{1'b0}};
        end
        if (state_q == ST_WR) begin
            bus_write_data = st_word_s;
        end else begin
            bus_write_data = {DATA_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Self-checking bench for lsu_bus_master: directed scenarios around the word
// 0x8899AABB at 0x80000010, an asynchronous reset during a write, then
// randomized traffic checked cycle by cycle against a transaction-level model.
module tb_lsu_bus_master;

`ifdef LSU_RMW_EN
    localparam bit RMW = 1'b1;
`else
    localparam bit RMW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_fault;
    logic [31:0] resp_rdata;
    logic [3:0]  resp_cause;
    logic        bus_rw, bus_selected;
    logic [31:0] bus_address, bus_write_data, bus_read_data;

    always #5 clk = ~clk;

    lsu_bus_master dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .resp_cause(resp_cause), .bus_rw(bus_rw),
        .bus_address(bus_address), .bus_write_data(bus_write_data),
        .bus_read_data(bus_read_data), .bus_selected(bus_selected)
    );

    // Responder: 64 words of main memory at 0x80000000, nothing else mapped.
    logic [31:0] mem [0:63];
    logic [31:0] ref_mem [0:63];
    logic        poke_en = 1'b0;
    logic [5:0]  poke_idx;
    logic [31:0] poke_val;

    assign bus_selected  = (bus_address[31:8] == 24'h800000);
    assign bus_read_data = mem[bus_address[7:2]];

    always @(posedge clk) begin
        if (poke_en) mem[poke_idx] <= poke_val;
        else if (bus_rw && bus_selected) mem[bus_address[7:2]] <= bus_write_data;
    end

    // Expected per-cycle bus/response behaviour of each accepted request.
    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        rv;
        logic        fault;
        logic [3:0]  cause;
        logic [31:0] rdata;
    } phase_t;

    phase_t      q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          issue_cyc = 0;
    int          resp_cyc = 0;
    bit          busy = 1'b0;
    logic [31:0] hold_rdata = 32'd0;
    logic        hold_fault = 1'b0;
    logic [31:0] last_rdata = 32'd0;
    logic        last_fault = 1'b0;
    logic [3:0]  last_cause = 4'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ld_extract(input logic [31:0] w, input int es,
                                               input bit uns, input logic [1:0] a);
        logic [31:0] v;
        int          nb;
        if (es == 2) return w;
        nb = (es == 0) ? 8 : 16;
        v  = (w >> (8 * a)) & ((32'd1 << nb) - 32'd1);
        if (!uns && v[nb-1]) v = v | (32'hFFFFFFFF << nb);
        return v;
    endfunction

    function automatic logic [31:0] st_merge(input logic [31:0] w, input int es,
                                             input logic [1:0] a, input logic [31:0] d);
        logic [31:0] mask;
        mask = ((es == 0) ? 32'h000000FF : 32'h0000FFFF) << (8 * a);
        return (w & ~mask) | ((d << (8 * a)) & mask);
    endfunction

    function automatic phase_t mk(input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                                  input logic rv, input logic fault, input logic [3:0] cause,
                                  input logic [31:0] rdata);
        phase_t p;
        p.rw = rw; p.addr = addr; p.wd = wd; p.rv = rv;
        p.fault = fault; p.cause = cause; p.rdata = rdata;
        return p;
    endfunction

    // Transaction-level model: derive the bus cycles and response of a request.
    task automatic model_push(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata);
        int          es;
        logic [31:0] al, nw;
        bit          mapped, mis;
        int          idx;
        es     = (size == 2'd3) ? 2 : int'(size);
        al     = {addr[31:2], 2'b00};
        mapped = (addr[31:8] == 24'h800000);
        idx    = int'(addr[7:2]);
        mis    = (es == 1 && addr[0]) || (es == 2 && addr[1:0] != 2'b00);
        if (mis) begin
            q.push_back(mk(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, we ? 4'd6 : 4'd4, 32'd0));
        end else if (we && es != 2 && !RMW) begin
            q.push_back(mk(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 4'd7, 32'd0));
        end else if (!we) begin
            q.push_back(mk(1'b0, al, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0));
            if (mapped) q.push_back(mk(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 4'd0,
                                       ld_extract(ref_mem[idx], es, uns, addr[1:0])));
            else q.push_back(mk(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 4'd5, 32'd0));
        end else if (es == 2) begin
            q.push_back(mk(1'b1, al, wdata, 1'b0, 1'b0, 4'd0, 32'd0));
            if (mapped) ref_mem[idx] = wdata;
            q.push_back(mk(1'b0, 32'd0, 32'd0, 1'b1, !mapped, mapped ? 4'd0 : 4'd7, 32'd0));
        end else begin
            q.push_back(mk(1'b0, al, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0));
            if (!mapped) begin
                q.push_back(mk(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 4'd7, 32'd0));
            end else begin
                nw = st_merge(ref_mem[idx], es, addr[1:0], wdata);
                ref_mem[idx] = nw;
                q.push_back(mk(1'b1, al, nw, 1'b0, 1'b0, 4'd0, 32'd0));
                q.push_back(mk(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 4'd0, 32'd0));
            end
        end
    endtask

    // Compare the DUT outputs of the current cycle against the model.
    task automatic check_cycle();
        phase_t ph;
        cyc++;
        busy = 1'b0;
        if (q.size() > 0) begin
            ph   = q.pop_front();
            busy = 1'b1;
            chk("bus_rw", 32'(bus_rw), 32'(ph.rw));
            chk("bus_address", bus_address, ph.addr);
            if (ph.rw) chk("bus_write_data", bus_write_data, ph.wd);
            chk("resp_valid", 32'(resp_valid), 32'(ph.rv));
            chk("req_ready_busy", 32'(req_ready), 32'd0);
            if (ph.rv) begin
                chk("resp_fault", 32'(resp_fault), 32'(ph.fault));
                if (ph.fault) chk("resp_cause", 32'(resp_cause), 32'(ph.cause));
                chk("resp_rdata", resp_rdata, ph.rdata);
                hold_rdata = ph.rdata;
                hold_fault = ph.fault;
                last_rdata = resp_rdata;
                last_fault = resp_fault;
                last_cause = resp_cause;
                resp_cyc   = cyc;
            end else begin
                chk("hold_rdata", resp_rdata, hold_rdata);
                chk("hold_fault", 32'(resp_fault), 32'(hold_fault));
            end
        end else begin
            chk("idle_bus_rw", 32'(bus_rw), 32'd0);
            chk("idle_bus_address", bus_address, 32'd0);
            chk("idle_resp_valid", 32'(resp_valid), 32'd0);
            chk("idle_req_ready", 32'(req_ready), 32'd1);
            chk("hold_rdata", resp_rdata, hold_rdata);
            chk("hold_fault", 32'(resp_fault), 32'(hold_fault));
        end
    endtask

    task automatic drive_junk();
        req_valid    = 1'($urandom);
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
    endtask

    // One cycle: check, then drive idle inputs (junk while the DUT is busy).
    task automatic step();
        @(negedge clk);
        check_cycle();
        if (busy) drive_junk();
        else req_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        do begin
            step();
            guard++;
        end while (busy && guard < 20);
        if (busy) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        int guard = 0;
        forever begin
            @(negedge clk);
            check_cycle();
            if (!busy) break;
            drive_junk();
            guard++;
            if (guard > 20) begin
                chk("req_ready_timeout", 32'd1, 32'd0);
                break;
            end
        end
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        issue_cyc = cyc;
        model_push(we, size, uns, addr, wdata);
    endtask

    task automatic poke(input int idx, input logic [31:0] val);
        poke_en = 1'b1; poke_idx = 6'(idx); poke_val = val;
        ref_mem[idx] = val;
        @(negedge clk);
        check_cycle();
        poke_en = 1'b0;
        req_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] sz;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; poke_idx = 6'd0; poke_val = 32'd0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_fault", 32'(resp_fault), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_cause", 32'(resp_cause), 32'd0);
        chk("rst_bus_rw", 32'(bus_rw), 32'd0);
        chk("rst_bus_address", bus_address, 32'd0);
        chk("rst_bus_write_data", bus_write_data, 32'd0);

        // Pin the model's lane arithmetic with hand-computed values.
        chk("model_ld_b_s", ld_extract(32'h8899AABB, 0, 1'b0, 2'd1), 32'hFFFFFFAA);
        chk("model_ld_h_s", ld_extract(32'h8899AABB, 1, 1'b0, 2'd2), 32'hFFFF8899);
        chk("model_st_h", st_merge(32'h8899AABB, 1, 2'd2, 32'h00001234), 32'h1234AABB);

        for (int i = 0; i < 64; i++) poke(i, $urandom);
        @(negedge clk);
        rst_n = 1'b1;
        poke(4, 32'h8899AABB);

        do_req(1'b0, 2'd0, 1'b0, 32'h80000011, 32'd0); drain();
        chk("ld_b_signed", last_rdata, 32'hFFFFFFAA);
        chk("ld_b_latency", 32'(resp_cyc - issue_cyc), 32'd2);
        do_req(1'b0, 2'd0, 1'b1, 32'h80000011, 32'd0); drain();
        chk("ld_b_unsigned", last_rdata, 32'h000000AA);
        do_req(1'b0, 2'd1, 1'b0, 32'h80000012, 32'd0); drain();
        chk("ld_h_signed", last_rdata, 32'hFFFF8899);

        do_req(1'b1, 2'd1, 1'b0, 32'h80000012, 32'h00001234); drain();
        if (RMW) begin
            chk("st_h_mem", mem[4], 32'h1234AABB);
            chk("st_h_latency", 32'(resp_cyc - issue_cyc), 32'd3);
            chk("st_h_fault", 32'(last_fault), 32'd0);
        end else begin
            chk("st_h_mem", mem[4], 32'h8899AABB);
            chk("st_h_cause", 32'(last_cause), 32'd7);
        end
        poke(4, 32'h8899AABB);

        do_req(1'b0, 2'd2, 1'b0, 32'h80000002, 32'd0); drain();
        chk("ld_w_mis_cause", 32'(last_cause), 32'd4);
        chk("ld_w_mis_latency", 32'(resp_cyc - issue_cyc), 32'd1);

        do_req(1'b1, 2'd2, 1'b0, 32'h00001000, 32'hDEADBEEF); drain();
        chk("st_unmapped_cause", 32'(last_cause), 32'd7);
        chk("st_unmapped_latency", 32'(resp_cyc - issue_cyc), 32'd2);

        do_req(1'b1, 2'd0, 1'b0, 32'h80000010, 32'h0000005C); drain();
        if (RMW) chk("st_b_mem", mem[4], 32'h8899AA5C);
        else begin
            chk("st_b_cause", 32'(last_cause), 32'd7);
            chk("st_b_latency", 32'(resp_cyc - issue_cyc), 32'd1);
            chk("st_b_mem", mem[4], 32'h8899AABB);
        end
        poke(4, 32'h8899AABB);

        // Reset asserted in the WR cycle of a store: nothing commits, no response.
        sz = RMW ? 2'd0 : 2'd2;
        do_req(1'b1, sz, 1'b0, 32'h80000010, 32'h00000077);
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus_rw) break;
        end
        chk("mid_rst_saw_wr", 32'(bus_rw), 32'd1);
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("mid_rst_bus_rw", 32'(bus_rw), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        q.delete();
        hold_rdata = 32'd0;
        hold_fault = 1'b0;
        ref_mem[4] = 32'h8899AABB;
        step(); step();
        rst_n = 1'b1;
        step(); step(); step();
        chk("mid_rst_mem", mem[4], 32'h8899AABB);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            if (($urandom % 8) == 0) a = 32'h00001000 | ($urandom & 32'hFF);
            else a = 32'h80000000 | ($urandom & 32'hFF);
            do_req(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
            if (($urandom % 4) == 0) drain();
        end
        drain();
        step();
        for (int i = 0; i < 64; i++) chk($sformatf("mem_%0d", i), mem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_bus_master.md
# lsu_bus_master

Load/store initiator that turns CPU data-memory requests (byte, half, word; signed or unsigned loads) into word-aligned accesses on the shared MMIO data bus. It sits between the execute stage and the bus responders (main memory at 0x80000000, peripherals) and drives the `rw`/`address`/`write_data` side of the bus protocol. It performs read-modify-write for sub-word stores, so every bus access is word-aligned. It reports misalignment and unmapped-address faults with RISC-V cause codes.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: bus data width (only 32 supported).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  CPU request present.
- `req_ready`  out  1  block accepts request (IDLE only).
- `req_we`  in  1  0 = load, 1 = store.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `req_unsigned`  in  1  zero-extend load result.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data (0 for stores).
- `resp_fault`  out  1  access faulted.
- `resp_cause`  out  4  4 = load misaligned, 5 = load access, 6 = store misaligned, 7 = store access.
- `bus_rw`  out  1  0 = read, 1 = write.
- `bus_address`  out  32  word-aligned address.
- `bus_write_data`  out  32  merged write word.
- `bus_read_data`  in  32  combinational read data from the responders.
- `bus_selected`  in  1  OR of all responder select lines.

## Operation
- FSM states: IDLE, RD, WR, RESP.
- IDLE: `req_ready` = 1. On `req_valid`, capture the request into registers.
  - Misaligned request: go to RESP with a fault. Half is misaligned when `addr[0]` = 1. Word is misaligned when `addr[1:0]` ≠ 0. Causes are 4 (load) or 6 (store).
  - Load or sub-word store: go to RD.
  - Word store: go to WR.
- RD: drive `bus_rw` = 0 and `bus_address` = `{addr[31:2], 2'b00}`. Capture `bus_read_data` at the cycle end.
  - If `bus_selected` = 0: go to RESP with cause 5 (load) or 7 (store).
  - Otherwise, loads go to RESP and sub-word stores go to WR.
- WR: drive `bus_rw` = 1, the aligned address, and the merged word. The responder commits at the cycle end.
  - If `bus_selected` = 0: `bus_rw` is still 1 but nothing is selected, so nothing commits. Go to RESP with cause 7.
- RESP: `resp_valid` = 1 for exactly one cycle, then return to IDLE. There is no response backpressure.
- Load lane extraction (little-endian):
  - Byte: lane `addr[1:0]`.
  - Half: bits `[16*addr[1] +: 16]`.
  - Sign-extend unless `req_unsigned`.
- Store merge: replace only the addressed byte/half lanes of the captured read word with `req_wdata[7:0]` / `req_wdata[15:0]`.
- Outside RD/WR: `bus_rw` = 0 and `bus_address` = 0. `bus_rw` is decoded from the state register, so no bus write exists outside WR.
- Faulted responses return `resp_rdata` = 0. The response fields hold their values until the next RESP.

## Timing
- Request accepted at edge N.
- Loads: RD in cycle N+1, `resp_valid` in N+2.
- Word store: WR in N+1, `resp_valid` in N+2.
- Sub-word store: RD in N+1, WR in N+2, `resp_valid` in N+3.
- Misaligned: `resp_valid` in N+1, with zero bus cycles.
- Next request is accepted no earlier than the cycle after RESP (IDLE).
- Reset values:
  - State IDLE, so `req_ready` = 1.
  - `resp_valid`, `resp_fault`, `bus_rw` = 0.
  - `resp_rdata`, `resp_cause`, `bus_address`, `bus_write_data` = 0.
- Reset mid-operation: `rst_n` low forces IDLE asynchronously, so `bus_rw` drops in the same cycle. No write commits, and no response is produced for the aborted request.
- `req_*` inputs are ignored outside IDLE.

## Configuration
- `LSU_RMW_EN` defined: sub-word stores use the RD→WR read-modify-write sequence.
- `LSU_RMW_EN` undefined:
  - Aligned byte/half stores fault with cause 7 in N+1 and perform no bus access.
  - Loads are unaffected.
  - The RD→WR transition and the merge logic are removed.

## Structure
- Shared package `lsu_pkg`:
  - size encodings (`SIZE_B`/`SIZE_H`/`SIZE_W`);
  - FSM state encoding;
  - cause constants `CAUSE_LD_MISALIGN` = 4, `CAUSE_LD_ACCESS` = 5, `CAUSE_ST_MISALIGN` = 6, `CAUSE_ST_ACCESS` = 7.
- Sub-module `lsu_lane_align`: purely combinational load extraction/extension and store merge, reused by the FSM top.

## Test plan
- All scenarios start from word 0x8899AABB at 0x80000010.
- Signed load byte at 0x80000011 → `resp_rdata` 0xFFFFFFAA at N+2. Unsigned → 0x000000AA. Signed half at 0x80000012 → 0xFFFF8899.
- Store half 0x1234 at 0x80000012 → bus read in N+1, bus write 0x1234AABB in N+2, `resp_valid` in N+3 with `resp_fault` = 0.
- Load word at 0x80000002 → `resp_fault` = 1, cause 4 at N+1. `bus_rw` stays 0 and `bus_address` stays 0.
- Store word to 0x00001000 with `bus_selected` = 0 → cause 7 at N+2, no responder writes.
- Assert `rst_n` during the WR cycle of a store byte → `bus_rw` falls immediately, memory stays 0x8899AABB, no `resp_valid`, and `req_ready` = 1 after release.
- Without `LSU_RMW_EN`: store byte to 0x80000010 → cause 7 at N+1 with no bus cycle. With it defined: word becomes 0x8899AA<data>.
